// File: rtl/fft16_ctrl.sv
// fft16_ctrl: sequencing controller for a 16-point R2SDF FFT datapath.
// Tracks the sample index under a global sample enable and decodes the
// per-stage butterfly selects, twiddle ROM addresses, output framing and a
// per-frame saturation flag. All decodes refer to the sample currently on din.
module fft16_ctrl #(
    parameter int N   = 16,
    parameter int LAT = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [3:0] sat_ovf,
    output logic [3:0] bf_sel,
    output logic [2:0] tw_en,
    output logic [2:0] tw_addr0,
    output logic [2:0] tw_addr1,
    output logic [2:0] tw_addr2,
    output logic       out_valid,
    output logic       out_last,
    output logic [3:0] out_idx,
    output logic       frame_ovf,
    output logic       busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [4:0]    fill_reg, fill_next;
    logic          ovf_acc_reg, ovf_acc_next;
    logic          frame_ovf_reg, frame_ovf_next;

    logic          en;
    logic          any_ovf;
    logic [CW-1:0] co;
    logic [3:0]    idx_rev;
    logic [2:0]    tw_addr_arr [3];

    assign en      = in_valid & ~clr;
    assign any_ovf = |sat_ovf;
    // Output-side index: the sample now on din leaves the FFT LAT samples later.
    assign co      = cnt_reg - CW'(LAT);

    // Per-stage decodes: stage k sees the stream delayed by its offset Lk and
    // alternates fill/butterfly halves of length Dk.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stage
            localparam int LK = (gi == 0) ? 0 : (gi == 1) ? 9 : (gi == 2) ? 14 : 17;
            localparam int DK = 8 >> gi;
            logic ph;
            assign ph          = 1'((cnt_reg - CW'(LK)) >> (3 - gi));
            assign bf_sel[gi]  = (int'(fill_reg) > LK) ? ph : 1'b0;
            if (gi < 3) begin : g_tw
                // Twiddles go on the differences leaving the feedback delay,
                // i.e. the pass-through half once the delay holds valid data.
                assign tw_en[gi] = (int'(fill_reg) > LK + DK) & ~ph;
                assign tw_addr_arr[gi] = tw_en[gi] ?
                    3'(((cnt_reg - CW'(LK)) & CW'(DK - 1)) << gi) : 3'd0;
            end
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_rev
            assign idx_rev[gi] = co[3 - gi];
        end
    endgenerate

    assign tw_addr0  = tw_addr_arr[0];
    assign tw_addr1  = tw_addr_arr[1];
    assign tw_addr2  = tw_addr_arr[2];
    // Index is held (not gated by in_valid) so a stall leaves it unchanged.
    assign out_idx   = (state_reg == RUN) ? idx_rev : 4'd0;
    assign frame_ovf = frame_ovf_reg;

    // Next-state logic for the FSM and counters, plus FSM-derived outputs.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        fill_next      = fill_reg;
        ovf_acc_next   = ovf_acc_reg;
        frame_ovf_next = frame_ovf_reg;
        busy           = (state_reg != IDLE);
        out_valid      = en & (state_reg == RUN);
        out_last       = out_valid & (co == CW'(N - 1));

        if (clr) begin
            state_next     = IDLE;
            cnt_next       = '0;
            fill_next      = '0;
            ovf_acc_next   = 1'b0;
            frame_ovf_next = 1'b0;
        end else if (in_valid) begin
            cnt_next  = cnt_reg + 1'b1;
            fill_next = (fill_reg == 5'(LAT)) ? fill_reg : fill_reg + 5'd1;
            case (state_reg)
                IDLE:    state_next = FILL;
                FILL:    if (fill_reg == 5'(LAT - 1)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
            // The frame boundary sample's own overflow belongs to the closing frame.
            if (out_last) begin
                ovf_acc_next   = 1'b0;
                frame_ovf_next = ovf_acc_reg | any_ovf;
            end else begin
                ovf_acc_next   = ovf_acc_reg | any_ovf;
            end
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            fill_reg      <= '0;
            ovf_acc_reg   <= 1'b0;
            frame_ovf_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            fill_reg      <= fill_next;
            ovf_acc_reg   <= ovf_acc_next;
            frame_ovf_reg <= frame_ovf_next;
        end
    end

endmodule

// File: tb/tb_fft16_ctrl.sv
// Testbench for fft16_ctrl: hand-derived vector table for a gap-free stream,
// per-cycle scoreboard against a sample-index model, and sequences for
// reset, stalls, overflow framing and soft restart.
module tb_fft16_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [3:0] sat_ovf;
    logic [3:0] bf_sel;
    logic [2:0] tw_en;
    logic [2:0] tw_addr0, tw_addr1, tw_addr2;
    logic       out_valid, out_last, frame_ovf, busy;
    logic [3:0] out_idx;

    fft16_ctrl #(.N(16), .LAT(19)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .sat_ovf(sat_ovf), .bf_sel(bf_sel), .tw_en(tw_en),
        .tw_addr0(tw_addr0), .tw_addr1(tw_addr1), .tw_addr2(tw_addr2),
        .out_valid(out_valid), .out_last(out_last), .out_idx(out_idx),
        .frame_ovf(frame_ovf), .busy(busy)
    );

    typedef struct packed {
        logic [3:0] bf;
        logic [2:0] twen;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [2:0] a2;
        logic       ov;
        logic       last;
        logic [3:0] idx;
        logic       busy;
    } outs_t;

    typedef struct {
        int    s;
        outs_t exp;
    } vec_t;

    outs_t dut_o;
    assign dut_o = {bf_sel, tw_en, tw_addr0, tw_addr1, tw_addr2,
                    out_valid, out_last, out_idx, busy};

    outs_t q[$];
    outs_t obs_cont [64];
    vec_t  vecs [14];
    int    s;
    int    n_cmp;
    int    n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] bitrev(input int v);
        logic [3:0] b;
        logic [3:0] r;
        b = 4'(v);
        for (int i = 0; i < 4; i++) r[i] = b[3 - i];
        return r;
    endfunction

    // Expected outputs for the cycle holding enabled sample s (since restart).
    function automatic outs_t model(input int sidx, input bit en);
        outs_t e;
        int    offs [4];
        int    l, d, addr;
        bit    half;
        offs = '{0, 9, 14, 17};
        e = '0;
        for (int k = 0; k < 4; k++) begin
            l = offs[k];
            d = 8 >> k;
            if (sidx > l) begin
                half = (((sidx - l) / d) % 2) == 1;
                e.bf[k] = half;
                if (k < 3 && sidx > l + d && !half) begin
                    e.twen[k] = 1'b1;
                    addr = ((sidx - l) % d) * (1 << k);
                    if (k == 0) e.a0 = 3'(addr);
                    else if (k == 1) e.a1 = 3'(addr);
                    else e.a2 = 3'(addr);
                end
            end
        end
        if (sidx >= 19) e.idx = bitrev((sidx - 19) % 16);
        e.ov   = en && sidx >= 19;
        e.last = e.ov && ((sidx - 19) % 16) == 15;
        e.busy = sidx > 0;
        return e;
    endfunction

    function automatic vec_t mk(input int sidx, input logic [3:0] bf, input logic [2:0] twen,
                                input int a0, input int a1, input int a2, input bit ov,
                                input bit last, input int idx, input bit bsy);
        vec_t v;
        v.s   = sidx;
        v.exp = {bf, twen, 3'(a0), 3'(a1), 3'(a2), ov, last, 4'(idx), bsy};
        return v;
    endfunction

    task automatic cmp_outs(input string name, input outs_t got, input outs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s s=%0d got=%h required=%h", name, s, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s s=%0d got=%0d required=%0d", name, s, got, exp);
        end
    endtask

    // One clock: drive at posedge+1, push expectation, compare at negedge.
    task automatic step(input bit v, input bit c, input logic [3:0] so, output outs_t got);
        outs_t e;
        in_valid = v;
        clr      = c;
        sat_ovf  = so;
        q.push_back(model(s, v && !c));
        @(negedge clk);
        got = dut_o;
        if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty s=%0d", s);
        end else begin
            e = q.pop_front();
            cmp_outs("cycle", got, e);
            $display("txn s=%0d v=%0d clr=%0d sat=%h out=%h", s, v, c, so, got);
        end
        @(posedge clk);
        #1;
        if (c) s = 0;
        else if (v) s++;
    endtask

    initial begin
        outs_t got;
        int    first;
        bit    p1, p3;
        n_cmp    = 0;
        n_fail   = 0;
        s        = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        sat_ovf  = 4'd0;

        vecs[0]  = mk(0,  4'b0000, 3'b000, 0, 0, 0, 0, 0, 0,  0);
        vecs[1]  = mk(8,  4'b0001, 3'b000, 0, 0, 0, 0, 0, 0,  1);
        vecs[2]  = mk(16, 4'b0110, 3'b001, 0, 0, 0, 0, 0, 0,  1);
        vecs[3]  = mk(17, 4'b0100, 3'b011, 1, 0, 0, 0, 0, 0,  1);
        vecs[4]  = mk(18, 4'b1000, 3'b111, 2, 2, 0, 0, 0, 0,  1);
        vecs[5]  = mk(19, 4'b0000, 3'b111, 3, 4, 4, 1, 0, 0,  1);
        vecs[6]  = mk(20, 4'b1100, 3'b011, 4, 6, 0, 1, 0, 8,  1);
        vecs[7]  = mk(21, 4'b0110, 3'b001, 5, 0, 0, 1, 0, 4,  1);
        vecs[8]  = mk(22, 4'b1010, 3'b101, 6, 0, 0, 1, 0, 12, 1);
        vecs[9]  = mk(23, 4'b0010, 3'b101, 7, 0, 4, 1, 0, 2,  1);
        vecs[10] = mk(24, 4'b1111, 3'b000, 0, 0, 0, 1, 0, 10, 1);
        vecs[11] = mk(34, 4'b1000, 3'b111, 2, 2, 0, 1, 1, 15, 1);
        vecs[12] = mk(35, 4'b0000, 3'b111, 3, 4, 4, 1, 0, 0,  1);
        vecs[13] = mk(50, 4'b1000, 3'b111, 2, 2, 0, 1, 1, 15, 1);

        // Reset state while rst_n is held low.
        #23;
        cmp_outs("reset_outputs", dut_o, '0);
        chk_int("reset_frame_ovf", int'(frame_ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Gap-free stream, checked per cycle and against the hand table.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 4'd0, got);
            obs_cont[i] = got;
        end
        for (int i = 0; i < 14; i++) cmp_outs("table", obs_cont[vecs[i].s], vecs[i].exp);

        // Restart, then a stream with about 30% idle cycles.
        step(1'b0, 1'b1, 4'd0, got);
        while (s < 80) begin
            if ($urandom_range(0, 99) < 30) step(1'b0, 1'b0, 4'd0, got);
            else step(1'b1, 1'b0, 4'd0, got);
        end

        // Asynchronous reset mid-stream, away from the clock edge.
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        cmp_outs("async_reset_outputs", dut_o, '0);
        chk_int("async_reset_frame_ovf", int'(frame_ovf), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, got);

        // Overflow framing, including sat_ovf pulses during idle cycles.
        p1 = 1'b0;
        p3 = 1'b0;
        while (s < 86) begin
            if (s == 20 && !p1) begin
                step(1'b0, 1'b0, 4'b1111, got);
                p1 = 1'b1;
            end else if (s == 58 && !p3) begin
                step(1'b0, 1'b0, 4'b1111, got);
                p3 = 1'b1;
            end else begin
                step(1'b1, 1'b0, (s == 40 || s == 70) ? 4'b0100 : 4'b0000, got);
            end
            chk_int("frame_ovf", int'(frame_ovf), ((s >= 51 && s < 67) || s >= 83) ? 1 : 0);
        end

        // clr together with in_valid while frame_ovf is set.
        step(1'b1, 1'b1, 4'd0, got);
        chk_int("clr_frame_ovf", int'(frame_ovf), 0);
        chk_int("clr_busy", int'(busy), 0);

        // Fresh stream, clr at sample 25, then restart timing.
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 4'd0, got);
        step(1'b1, 1'b1, 4'd0, got);
        chk_int("clr25_busy", int'(busy), 0);
        chk_int("clr25_frame_ovf", int'(frame_ovf), 0);
        first = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 4'd0, got);
            if (got.ov && first < 0) first = i;
        end
        chk_int("first_valid_after_clr", first, 19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
